rsa_word_io: RTL and testbench
==============================

# rsa_word_io

Word-serial host front end for the 256-bit RSA modular-exponentiation engine. It collects operands over a 32-bit register-write port, holds the engine's active-low reset until a start command, and waits for the engine's end flag with a watchdog. It then captures the 256-bit result and streams it back as eight 32-bit words over a valid/ready handshake. It sits between the host bus and the engine: it drives the engine's inputs and consumes its output.

## Interface
- WORDS, 8: 32-bit words per 256-bit operand/result; fixed at 8.
- TIMEOUT, 4096: maximum RUN-state cycles before abort; 2..2^20.

- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- wr_en  in  1  operand write strobe.
- wr_addr  in  5  0-7: indata word n; 8-15: modulus word n-8; 16: pow; 17: mp; 18-31: ignored.
- wr_data  in  32  write data.
- start  in  1  launch request, single-cycle.
- busy  out  1  high in RUN and SEND.
- done  out  1  one-cycle pulse after the final result word is accepted.
- err  out  1  sticky timeout flag.
- out_valid  out  1  result word valid.
- out_ready  in  1  consumer accepts word.
- out_data  out  32  result word; word 0 = bits 31:0 is sent first.
- out_last  out  1  high with word 7.
- eng_rst  out  1  engine reset, active-low: 0 holds the engine in reset.
- eng_indata, eng_modulos  out  256  operand registers.
- eng_pow, eng_mp  out  32  exponent and Montgomery constant.
- eng_outdata  in  256  engine result.
- eng_endflag  in  1  engine completion flag; treated as a level.

## Operation
- States: IDLE, RUN, SEND.
- Reset (rst=1 on a clock edge):
  - State goes to IDLE.
  - All operand registers, result register, word index and cycle counter clear to 0.
  - Outputs: eng_rst=0, busy=0, done=0, err=0, out_valid=0, out_last=0, out_data=0.
- IDLE:
  - wr_en writes the 32-bit slice selected by wr_addr. Indata/modulus word n occupies bits 32n+31:32n.
  - start=1 → RUN. On that edge: eng_rst←1, busy←1, cycle counter←0, err←0.
  - wr_en together with start in the same cycle: the write is applied, and the engine sees the new value.
- RUN:
  - Counter increments each cycle.
  - eng_endflag=1 → result←eng_outdata, eng_rst←0, word index←0, state SEND.
  - Counter reaches TIMEOUT-1 with eng_endflag=0 → err←1, eng_rst←0, busy←0, state IDLE; no output words are produced.
  - eng_endflag=1 in the same cycle as the timeout: the end flag wins, and err stays 0.
- SEND:
  - out_valid=1; out_data = result word[index]; out_last = (index==7).
  - On out_valid&&out_ready: index increments.
  - On the handshake at index 7: out_valid←0, busy←0, done←1 for one cycle, state IDLE.
  - out_data and out_last stay stable while out_ready=0.
- Outside IDLE, writes and start are ignored; operand registers are frozen for the whole run.
- Unmapped write addresses have no effect.

## Timing
- start sampled at edge T → busy=1 and eng_rst=1 from T+1.
- eng_endflag sampled high at edge E → eng_rst=0 and out_valid=1 with word 0 from E+1.
- With out_ready held at 1, one word per cycle: word k is visible at E+1+k.
- Last handshake at edge L → done=1 during L+1 only, with busy=0 and out_valid=0.
- Timeout: start at T → err=1, busy=0, eng_rst=0 at T+TIMEOUT.
- A new start is accepted in the cycle that done is high.
- Reset has priority over every other input, in any state.

## Test plan
- Write 0x11111110+n to addr n (n=0..7), 0xF0000000|n to 8+n, 0x00010001 to 16, 0x89ABCDEF to 17 → eng_indata[31:0]=0x11111110, eng_indata[255:224]=0x11111117, eng_modulos[255:224]=0xF0000007, eng_pow=0x00010001, eng_mp=0x89ABCDEF, eng_rst=0.
- Stub engine raises eng_endflag 100 cycles after eng_rst rises, with eng_outdata=256'h0000000700000006…0000000000 → eng_rst=1 one cycle after start; out words 0,1,…,7 on consecutive cycles with out_ready=1; out_last only on word 7; done pulse one cycle after.
- Same run with out_ready toggling 1,0,0,1… → every word sent exactly once, in order, held stable while out_ready=0; done is still a single pulse.
- TIMEOUT=64, stub never ends → err=1, busy=0, eng_rst=0 exactly 64 cycles after the start edge; no out_valid; the next start clears err.
- During RUN: wr_en to addr 0 with 0xDEADBEEF, plus start=1 → eng_indata unchanged and no restart. rst=1 after 3 words of SEND → next cycle out_valid=0, busy=0, all operands 0.

Source files
------------

// File: rtl/rsa_word_io_if.sv
// rsa_word_io_if
// Host-side bus of the RSA word-serial front end: the operand write port,
// the start/status signals and the 32-bit result stream.
//
// Handshake semantics (result stream): a word transfers on every rising
// clock edge where out_valid && out_ready are both high. While out_valid is
// high and out_ready is low, the producer holds out_data and out_last
// stable. out_valid never depends combinationally on out_ready.
//
// Modports:
//   master - host / consumer side (drives writes, start, out_ready)
//   slave  - rsa_word_io side (drives status and the result stream)
interface rsa_word_io_if;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        start;
    logic        busy;
    logic        done;
    logic        err;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;

    modport master (
        output wr_en, wr_addr, wr_data, start, out_ready,
        input  busy, done, err, out_valid, out_data, out_last
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start, out_ready,
        output busy, done, err, out_valid, out_data, out_last
    );
endinterface

// File: rtl/rsa_word_io.sv
// rsa_word_io
// Word-serial host front end for a 256-bit RSA modular-exponentiation
// engine. Operands are loaded through 32-bit register writes while IDLE;
// start releases the engine reset (RUN); on the engine end flag the result
// is captured and streamed back as eight 32-bit words (SEND). A watchdog
// aborts RUN after TIMEOUT cycles and sets a sticky err flag.
//
// Ports:
//   clk, rst       - clock, synchronous active-high reset
//   bus            - rsa_word_io_if.slave (writes, start, status, stream)
//   eng_rst        - engine reset, active-low (0 holds engine in reset)
//   eng_indata     - 256-bit input data operand
//   eng_modulos    - 256-bit modulus operand
//   eng_pow        - 32-bit exponent
//   eng_mp         - 32-bit Montgomery constant
//   eng_outdata    - 256-bit engine result
//   eng_endflag    - engine completion flag (level)
//   dbg_state      - current FSM state (IDLE=0, RUN=1, SEND=2)
module rsa_word_io #(
    parameter int WORDS   = 8,
    parameter int TIMEOUT = 4096
) (
    input  logic          clk,
    input  logic          rst,
    rsa_word_io_if.slave  bus,
    output logic          eng_rst,
    output logic [255:0]  eng_indata,
    output logic [255:0]  eng_modulos,
    output logic [31:0]   eng_pow,
    output logic [31:0]   eng_mp,
    input  logic [255:0]  eng_outdata,
    input  logic          eng_endflag,
    output logic [1:0]    dbg_state
);

    localparam int             CW       = $clog2(TIMEOUT);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [2:0]     IDX_LAST = 3'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SEND = 2'd2
    } state_t;

    state_t         state_q,   state_d;
    logic [255:0]   indata_q,  indata_d;
    logic [255:0]   modulos_q, modulos_d;
    logic [31:0]    pow_q,     pow_d;
    logic [31:0]    mp_q,      mp_d;
    logic [255:0]   result_q,  result_d;
    logic [2:0]     idx_q,     idx_d;
    logic [CW-1:0]  cnt_q,     cnt_d;
    logic           eng_rst_q, eng_rst_d;
    logic           busy_q,    busy_d;
    logic           done_q,    done_d;
    logic           err_q,     err_d;
    logic [31:0]    word_sel;

    // Result word currently addressed by the send index.
    always_comb begin
        word_sel = 32'd0;
        for (int i = 0; i < 8; i++) begin
            if (idx_q == 3'(i)) begin
                word_sel = result_q[32*i +: 32];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        indata_d  = indata_q;
        modulos_d = modulos_q;
        pow_d     = pow_q;
        mp_d      = mp_q;
        result_d  = result_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        eng_rst_d = eng_rst_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = err_q;

        case (state_q)
            IDLE: begin
                // Writes land on the same edge as a simultaneous start, so
                // the engine is released with the freshly written value.
                if (bus.wr_en) begin
                    for (int i = 0; i < 8; i++) begin
                        if (bus.wr_addr == 5'(i)) begin
                            indata_d[32*i +: 32] = bus.wr_data;
                        end
                        if (bus.wr_addr == 5'(i + 8)) begin
                            modulos_d[32*i +: 32] = bus.wr_data;
                        end
                    end
                    if (bus.wr_addr == 5'd16) begin
                        pow_d = bus.wr_data;
                    end
                    if (bus.wr_addr == 5'd17) begin
                        mp_d = bus.wr_data;
                    end
                end
                if (bus.start) begin
                    state_d   = RUN;
                    eng_rst_d = 1'b1;
                    busy_d    = 1'b1;
                    cnt_d     = '0;
                    err_d     = 1'b0;
                end
            end

            RUN: begin
                cnt_d = cnt_q + 1'b1;
                // End flag is checked first so it wins over a same-cycle
                // watchdog expiry.
                if (eng_endflag) begin
                    result_d  = eng_outdata;
                    eng_rst_d = 1'b0;
                    idx_d     = 3'd0;
                    state_d   = SEND;
                end else if (cnt_q == CNT_LAST) begin
                    err_d     = 1'b1;
                    eng_rst_d = 1'b0;
                    busy_d    = 1'b0;
                    state_d   = IDLE;
                end
            end

            SEND: begin
                if (bus.out_ready) begin
                    idx_d = idx_q + 1'b1;
                    if (idx_q == IDX_LAST) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            indata_q  <= '0;
            modulos_q <= '0;
            pow_q     <= '0;
            mp_q      <= '0;
            result_q  <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            eng_rst_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            indata_q  <= indata_d;
            modulos_q <= modulos_d;
            pow_q     <= pow_d;
            mp_q      <= mp_d;
            result_q  <= result_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            eng_rst_q <= eng_rst_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.out_valid = (state_q == SEND);
    assign bus.out_data  = (state_q == SEND) ? word_sel : 32'd0;
    assign bus.out_last  = (state_q == SEND) && (idx_q == IDX_LAST);

    assign eng_rst     = eng_rst_q;
    assign eng_indata  = indata_q;
    assign eng_modulos = modulos_q;
    assign eng_pow     = pow_q;
    assign eng_mp      = mp_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_rsa_word_io.sv
module tb_rsa_word_io;

    localparam int TO = 128;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rsa_word_io_if bus ();

    logic         eng_rst;
    logic [255:0] eng_indata;
    logic [255:0] eng_modulos;
    logic [31:0]  eng_pow;
    logic [31:0]  eng_mp;
    logic [255:0] eng_outdata;
    logic         eng_endflag;
    logic [1:0]   dbg_state;

    rsa_word_io #(.WORDS(8), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .eng_rst     (eng_rst),
        .eng_indata  (eng_indata),
        .eng_modulos (eng_modulos),
        .eng_pow     (eng_pow),
        .eng_mp      (eng_mp),
        .eng_outdata (eng_outdata),
        .eng_endflag (eng_endflag),
        .dbg_state   (dbg_state)
    );

    // ---------------- scoreboard / reference model ----------------
    int checks = 0;
    int errors = 0;
    logic [31:0] m_ind [8];
    logic [31:0] m_mod [8];
    logic [31:0] m_pow;
    logic [31:0] m_mp;
    logic [31:0] exp_q [$];

    typedef struct {
        logic [4:0]   addr;
        logic [31:0]  data;
        logic [255:0] exp_ind;
        logic [255:0] exp_mod;
        logic [31:0]  exp_pow;
        logic [31:0]  exp_mp;
    } wr_vec_t;

    wr_vec_t vecs [20];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) begin
            m_ind[i] = 32'd0;
            m_mod[i] = 32'd0;
        end
        m_pow = 32'd0;
        m_mp  = 32'd0;
    endtask

    task automatic model_write(input logic [4:0] addr, input logic [31:0] data);
        if (addr < 5'd8)       m_ind[addr[2:0]] = data;
        else if (addr < 5'd16) m_mod[addr[2:0]] = data;
        else if (addr == 5'd16) m_pow = data;
        else if (addr == 5'd17) m_mp = data;
    endtask

    function automatic logic [255:0] ind_vec();
        logic [255:0] v = '0;
        for (int i = 0; i < 8; i++) v = v | (256'(m_ind[i]) << (32 * i));
        return v;
    endfunction

    function automatic logic [255:0] mod_vec();
        logic [255:0] v = '0;
        for (int i = 0; i < 8; i++) v = v | (256'(m_mod[i]) << (32 * i));
        return v;
    endfunction

    task automatic chk_operands(input string tag);
        chk({tag, "_indata"},  eng_indata,  ind_vec());
        chk({tag, "_modulos"}, eng_modulos, mod_vec());
        chk({tag, "_pow"},     eng_pow,     m_pow);
        chk({tag, "_mp"},      eng_mp,      m_mp);
    endtask

    // ---------------- driver tasks ----------------
    task automatic host_write(input logic [4:0] addr, input logic [31:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_addr = addr;
        bus.wr_data = data;
        step();
        bus.wr_en   = 1'b0;
        model_write(addr, data);
    endtask

    function automatic bit ready_pat(input int mode, input int cyc);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (cyc % 3) == 0;
        return 1'($urandom_range(0, 1));
    endfunction

    // One complete job: start (optionally with a same-cycle write), engine
    // finishes after `delay` RUN cycles, result drained with ready pattern.
    // reset_after >= 0 asserts rst after that many words were accepted.
    task automatic run_job(input int delay, input int rmode, input logic [255:0] res,
                           input bit poke, input bit ww, input logic [4:0] wa,
                           input logic [31:0] wd, input int reset_after);
        int          cyc;
        int          acc;
        bit          holding;
        bit          r;
        logic [31:0] held;
        logic [31:0] w;

        bus.start = 1'b1;
        if (ww) begin
            bus.wr_en   = 1'b1;
            bus.wr_addr = wa;
            bus.wr_data = wd;
        end
        step();
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
        if (ww) begin
            model_write(wa, wd);
            chk_operands("start_write");
        end
        chk("start_busy",    bus.busy,      1'b1);
        chk("start_eng_rst", eng_rst,       1'b1);
        chk("start_err",     bus.err,       1'b0);
        chk("start_valid",   bus.out_valid, 1'b0);

        for (int k = 0; k < delay; k++) begin
            if (poke && k == delay / 2) begin
                bus.wr_en   = 1'b1;
                bus.wr_addr = 5'd0;
                bus.wr_data = 32'hDEADBEEF;
                bus.start   = 1'b1;
                step();
                bus.wr_en   = 1'b0;
                bus.start   = 1'b0;
                chk("run_write_ignored", eng_indata, ind_vec());
                chk("run_busy",          bus.busy,   1'b1);
                chk("run_eng_rst",       eng_rst,    1'b1);
            end else begin
                step();
            end
        end

        eng_outdata = res;
        eng_endflag = 1'b1;
        step();
        eng_endflag = 1'b0;
        eng_outdata = {$urandom, $urandom, $urandom, $urandom,
                       $urandom, $urandom, $urandom, $urandom};
        chk("end_eng_rst", eng_rst,       1'b0);
        chk("end_valid",   bus.out_valid, 1'b1);
        chk("end_busy",    bus.busy,      1'b1);
        chk("end_err",     bus.err,       1'b0);

        exp_q.delete();
        for (int k = 0; k < 8; k++) exp_q.push_back(32'((res >> (32 * k)) & 256'hFFFFFFFF));

        cyc = 0;
        acc = 0;
        holding = 1'b0;
        held = 32'd0;
        while (exp_q.size() > 0 && cyc < 400) begin
            chk("send_valid", bus.out_valid, 1'b1);
            if (holding) chk("hold_data", bus.out_data, held);
            r = ready_pat(rmode, cyc);
            bus.out_ready = r;
            if (r) begin
                w = exp_q.pop_front();
                chk("word_data", bus.out_data, w);
                chk("word_last", bus.out_last, exp_q.size() == 0);
                holding = 1'b0;
                acc++;
            end else begin
                held = bus.out_data;
                holding = 1'b1;
            end
            step();
            cyc++;
            if (reset_after >= 0 && acc == reset_after) begin
                bus.out_ready = 1'b0;
                rst = 1'b1;
                step();
                rst = 1'b0;
                model_clear();
                exp_q.delete();
                chk("rst_valid",   bus.out_valid, 1'b0);
                chk("rst_busy",    bus.busy,      1'b0);
                chk("rst_done",    bus.done,      1'b0);
                chk("rst_eng_rst", eng_rst,       1'b0);
                chk("rst_data",    bus.out_data,  32'd0);
                chk_operands("rst");
                return;
            end
        end
        bus.out_ready = 1'b0;
        if (exp_q.size() > 0) begin
            chk("send_budget_words_left", 256'(exp_q.size()), 256'd0);
            exp_q.delete();
        end
        chk("done_pulse",   bus.done,      1'b1);
        chk("done_busy",    bus.busy,      1'b0);
        chk("done_valid",   bus.out_valid, 1'b0);
        chk("done_last",    bus.out_last,  1'b0);
        step();
        chk("done_single",  bus.done,      1'b0);
    endtask

    task automatic timeout_job();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int k = 1; k < TO; k++) begin
            step();
            if (bus.out_valid !== 1'b0 || bus.busy !== 1'b1 || bus.err !== 1'b0)
                chk("to_running", {bus.out_valid, bus.busy, bus.err}, 3'b010);
        end
        chk("to_busy_before", bus.busy, 1'b1);
        step();
        chk("to_err",     bus.err,       1'b1);
        chk("to_busy",    bus.busy,      1'b0);
        chk("to_eng_rst", eng_rst,       1'b0);
        chk("to_valid",   bus.out_valid, 1'b0);
        step();
        chk("to_err_sticky", bus.err,       1'b1);
        chk("to_no_valid",   bus.out_valid, 1'b0);
    endtask

    // ---------------- test ----------------
    logic [255:0] ei, em, plan_res, rres;
    logic [31:0]  ep, emp;

    initial begin
        rst           = 1'b1;
        bus.wr_en     = 1'b0;
        bus.wr_addr   = 5'd0;
        bus.wr_data   = 32'd0;
        bus.start     = 1'b0;
        bus.out_ready = 1'b0;
        eng_outdata   = '0;
        eng_endflag   = 1'b0;
        model_clear();

        // Vector table: each write with the full expected operand state after it.
        ei = '0; em = '0; ep = '0; emp = '0;
        for (int n = 0; n < 8; n++) begin
            ei[32*n +: 32] = 32'h11111110 + 32'(n);
            vecs[n] = '{5'(n), 32'h11111110 + 32'(n), ei, em, ep, emp};
        end
        for (int n = 0; n < 8; n++) begin
            em[32*n +: 32] = 32'hF0000000 | 32'(n);
            vecs[8+n] = '{5'(8 + n), 32'hF0000000 | 32'(n), ei, em, ep, emp};
        end
        ep = 32'h00010001;
        vecs[16] = '{5'd16, 32'h00010001, ei, em, ep, emp};
        emp = 32'h89ABCDEF;
        vecs[17] = '{5'd17, 32'h89ABCDEF, ei, em, ep, emp};
        vecs[18] = '{5'd18, 32'hFFFFFFFF, ei, em, ep, emp};
        vecs[19] = '{5'd31, 32'h55555555, ei, em, ep, emp};

        step();
        step();
        rst = 1'b0;
        chk("rst_busy0",    bus.busy,      1'b0);
        chk("rst_done0",    bus.done,      1'b0);
        chk("rst_err0",     bus.err,       1'b0);
        chk("rst_valid0",   bus.out_valid, 1'b0);
        chk("rst_last0",    bus.out_last,  1'b0);
        chk("rst_data0",    bus.out_data,  32'd0);
        chk("rst_eng_rst0", eng_rst,       1'b0);
        chk_operands("rst0");

        for (int i = 0; i < 20; i++) begin
            host_write(vecs[i].addr, vecs[i].data);
            chk("vec_indata",  eng_indata,  vecs[i].exp_ind);
            chk("vec_modulos", eng_modulos, vecs[i].exp_mod);
            chk("vec_pow",     eng_pow,     vecs[i].exp_pow);
            chk("vec_mp",      eng_mp,      vecs[i].exp_mp);
        end
        chk("plan_ind_lo", eng_indata[31:0],    32'h11111110);
        chk("plan_ind_hi", eng_indata[255:224], 32'h11111117);
        chk("plan_mod_hi", eng_modulos[255:224], 32'hF0000007);
        chk("plan_pow",    eng_pow,             32'h00010001);
        chk("plan_mp",     eng_mp,              32'h89ABCDEF);
        chk("plan_eng_rst", eng_rst,            1'b0);
        chk("plan_busy",   bus.busy,            1'b0);

        plan_res = '0;
        for (int k = 0; k < 8; k++) plan_res[32*k +: 32] = 32'(k);

        run_job(99, 0, plan_res, 1'b0, 1'b0, 5'd0, 32'd0, -1);
        run_job(99, 1, plan_res, 1'b0, 1'b0, 5'd0, 32'd0, -1);
        timeout_job();
        run_job(20, 0, plan_res, 1'b1, 1'b0, 5'd0, 32'd0, -1);
        chk_operands("after_poke");
        run_job(TO - 1, 0, ~plan_res, 1'b0, 1'b0, 5'd0, 32'd0, -1);
        run_job(5, 2, plan_res, 1'b0, 1'b1, 5'd17, 32'h13579BDF, -1);

        for (int j = 0; j < 6; j++) begin
            for (int k = 0; k < 10; k++) host_write(5'($urandom_range(0, 31)), $urandom);
            chk_operands("rand_load");
            rres = {$urandom, $urandom, $urandom, $urandom,
                    $urandom, $urandom, $urandom, $urandom};
            run_job($urandom_range(0, TO - 2), $urandom_range(0, 2), rres,
                    1'($urandom_range(0, 1)), 1'b0, 5'd0, 32'd0, -1);
            chk_operands("rand_frozen");
        end

        run_job(30, 0, plan_res, 1'b0, 1'b0, 5'd0, 32'd0, 3);
        host_write(5'd3, 32'hCAFEF00D);
        chk_operands("post_rst");
        run_job(7, 1, ~plan_res, 1'b0, 1'b0, 5'd0, 32'd0, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
